// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared encodings for the CPU memory port (arbiter FSM states,
//               transaction owner, load/store size codes, bus widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam int c_ADDR_W = 6;
    localparam int c_DATA_W = 32;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic c_OWN_IF = 1'b0;
    localparam logic c_OWN_D  = 1'b1;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/mem_latency_counter.sv
// ============================================================================
// Module      : mem_latency_counter
// Description : Loadable 3-bit down-counter; o_done flags the last count (1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_latency_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic       o_done
);

    logic [2:0] r_count_q;
    logic [2:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_dec && (r_count_q != 3'd0)) begin
            w_count_d = r_count_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= 3'd0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_done = (r_count_q == 3'd1);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory between instruction fetch and data access,
//               one transaction at a time, with fetch anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                    c_STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_SAT = c_STARVE_W'(STARVE_MAX);
    localparam logic [2:0]            c_LAT_LOAD   = 3'(MEM_LATENCY);

    generate
        if ((MEM_LATENCY < 1) || (MEM_LATENCY > 7)) begin : g_bad_latency
            $error("mem_port_arbiter: MEM_LATENCY must be within 1..7");
        end
    endgenerate

    logic [1:0]            r_state_q,    w_state_d;
    logic                  r_owner_q,    w_owner_d;
    logic [ADDR_W-1:0]     r_addr_q,     w_addr_d;
    logic                  r_we_q,       w_we_d;
    logic [2:0]            r_funct3_q,   w_funct3_d;
    logic [DATA_W-1:0]     r_wdata_q,    w_wdata_d;
    logic [c_STARVE_W-1:0] r_starve_q,   w_starve_d;
    logic [DATA_W-1:0]     r_if_rdata_q, w_if_rdata_d;
    logic [DATA_W-1:0]     r_d_rdata_q,  w_d_rdata_d;

    logic w_idle;
    logic w_starved;
    logic w_if_win;
    logic w_d_win;
    logic w_lat_done;

    assign w_idle    = (r_state_q == c_ST_IDLE);
    assign w_starved = (r_starve_q == c_STARVE_SAT);
    assign w_if_win  = w_idle & if_req & (~d_req | w_starved);
    assign w_d_win   = w_idle & d_req & ~(if_req & w_starved);

    mem_latency_counter u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state_q == c_ST_ISSUE),
        .i_load_val (c_LAT_LOAD),
        .i_dec      (r_state_q == c_ST_WAIT),
        .o_done     (w_lat_done)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_owner_d    = r_owner_q;
        w_addr_d     = r_addr_q;
        w_we_d       = r_we_q;
        w_funct3_d   = r_funct3_q;
        w_wdata_d    = r_wdata_q;
        w_if_rdata_d = r_if_rdata_q;
        w_d_rdata_d  = r_d_rdata_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_if_win || w_d_win) begin
                    w_state_d  = c_ST_ISSUE;
                    w_owner_d  = w_d_win ? c_OWN_D : c_OWN_IF;
                    w_addr_d   = w_d_win ? d_addr : if_addr;
                    w_we_d     = w_d_win & d_we;
                    w_funct3_d = w_d_win ? d_funct3 : c_F3_LW;
                    w_wdata_d  = w_d_win ? d_wdata : '0;
                end
            end
            c_ST_ISSUE: w_state_d = c_ST_WAIT;
            c_ST_WAIT: begin
                // Read data lands straight in the owner's holding register, so
                // it becomes visible together with the rvalid pulse.
                if (w_lat_done) begin
                    w_state_d = c_ST_RESP;
                    if (r_owner_q == c_OWN_IF) begin
                        w_if_rdata_d = mem_rdata;
                    end else begin
                        w_d_rdata_d = r_we_q ? '0 : mem_rdata;
                    end
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_starve_d = r_starve_q;
        if (w_if_win) begin
            w_starve_d = '0;
        end else if (w_d_win && if_req && !w_starved) begin
            w_starve_d = r_starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_IDLE;
            r_owner_q    <= c_OWN_IF;
            r_addr_q     <= '0;
            r_we_q       <= 1'b0;
            r_funct3_q   <= 3'd0;
            r_wdata_q    <= '0;
            r_starve_q   <= '0;
            r_if_rdata_q <= '0;
            r_d_rdata_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_owner_q    <= w_owner_d;
            r_addr_q     <= w_addr_d;
            r_we_q       <= w_we_d;
            r_funct3_q   <= w_funct3_d;
            r_wdata_q    <= w_wdata_d;
            r_starve_q   <= w_starve_d;
            r_if_rdata_q <= w_if_rdata_d;
            r_d_rdata_q  <= w_d_rdata_d;
        end
    end

    // Strobes are masked during reset so a dropped transaction emits nothing.
    assign if_gnt     = w_if_win & ~rst;
    assign d_gnt      = w_d_win & ~rst;
    assign if_rvalid  = (r_state_q == c_ST_RESP) & (r_owner_q == c_OWN_IF) & ~rst;
    assign d_rvalid   = (r_state_q == c_ST_RESP) & (r_owner_q == c_OWN_D) & ~rst;
    assign if_rdata   = r_if_rdata_q;
    assign d_rdata    = r_d_rdata_q;
    assign if_stall   = if_req & ~if_rvalid;
    assign d_stall    = d_req & ~d_rvalid;
    assign mem_en     = (r_state_q == c_ST_ISSUE) & ~rst;
    assign mem_we     = mem_en & r_we_q;
    assign mem_funct3 = r_funct3_q;
    assign mem_addr   = r_addr_q;
    assign mem_wdata  = r_wdata_q;

endmodule

`default_nettype wire
